// File: rtl/ex_stage.sv
// Execute stage: operand-2 generation, ALU, flag logic and the EX/MEM pipeline
// register. Branch target and branch-taken are combinational pass-throughs.
module ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   input  logic [31:0] val_Rn_in,
   input  logic [31:0] val_Rm_in,
   input  logic [23:0] signed_immediate_in,
   input  logic [11:0] shifter_operand_in,
   input  logic [3:0]  EX_command_in,
   input  logic [3:0]  status_register_in,
   input  logic [3:0]  reg_file_dst_in,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic        WB_en_in,
   input  logic        Imm_in,
   input  logic        B_in,
   input  logic        SR_update_in,
   input  logic        freeze,
   output logic [31:0] alu_result,
   output logic [31:0] store_data,
   output logic [3:0]  reg_file_dst_out,
   output logic        mem_read_out,
   output logic        mem_write_out,
   output logic        WB_en_out,
   output logic [3:0]  status_out,
   output logic        branch_taken,
   output logic [31:0] branch_addr
);

   localparam logic [3:0] OP_MOV = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_ADC = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_SBC = 4'b0101;
   localparam logic [3:0] OP_AND = 4'b0110;
   localparam logic [3:0] OP_ORR = 4'b0111;
   localparam logic [3:0] OP_EOR = 4'b1000;
   localparam logic [3:0] OP_MVN = 4'b1001;

   logic        is_mem;
   logic [4:0]  rot_amt;
   logic [4:0]  sh_amt;
   logic [63:0] imm_dbl;
   logic [63:0] imm_rot_dbl;
   logic [63:0] rm_dbl;
   logic [63:0] rm_ror_dbl;
   logic [31:0] val2;
   logic [31:0] add_b;
   logic        add_cin;
   logic [32:0] sum33;
   logic [31:0] result;
   logic        flag_c;
   logic        flag_v;
   logic [3:0]  flags;

   assign is_mem      = mem_read_in | mem_write_in;
   assign rot_amt     = {shifter_operand_in[11:8], 1'b0};
   assign sh_amt      = shifter_operand_in[11:7];
   // Rotations are done by shifting a doubled copy so the low word wraps.
   assign imm_dbl     = {2{24'b0, shifter_operand_in[7:0]}};
   assign imm_rot_dbl = imm_dbl >> rot_amt;
   assign rm_dbl      = {val_Rm_in, val_Rm_in};
   assign rm_ror_dbl  = rm_dbl >> sh_amt;

   // Second operand: 12-bit offset for memory ops, rotated immediate, or shifted Rm
   always_comb begin
      val2 = val_Rm_in;
      if (is_mem) begin
         val2 = {20'b0, shifter_operand_in};
      end else if (Imm_in) begin
         val2 = imm_rot_dbl[31:0];
      end else begin
         case (shifter_operand_in[6:5])
            2'b00:   val2 = val_Rm_in << sh_amt;
            2'b01:   val2 = val_Rm_in >> sh_amt;
            2'b10:   val2 = $signed(val_Rm_in) >>> sh_amt;
            default: val2 = rm_ror_dbl[31:0];
         endcase
      end
   end

   // One shared adder: subtraction is Rn + ~Val2 + carry-in, so C is NOT borrow
   always_comb begin
      add_b   = val2;
      add_cin = 1'b0;
      if (!is_mem) begin
         case (EX_command_in)
            OP_ADC:  add_cin = status_register_in[1];
            OP_SUB:  begin add_b = ~val2; add_cin = 1'b1; end
            OP_SBC:  begin add_b = ~val2; add_cin = status_register_in[1]; end
            default: add_cin = 1'b0;
         endcase
      end
   end

   assign sum33 = {1'b0, val_Rn_in} + {1'b0, add_b} + {32'b0, add_cin};

   // Result select and carry/overflow; non-arithmetic ops keep incoming C and V
   always_comb begin
      result = 32'b0;
      flag_c = status_register_in[1];
      flag_v = status_register_in[0];
      if (is_mem) begin
         result = sum33[31:0];
      end else begin
         case (EX_command_in)
            OP_MOV: result = val2;
            OP_MVN: result = ~val2;
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
               result = sum33[31:0];
               flag_c = sum33[32];
               flag_v = (val_Rn_in[31] == add_b[31]) && (sum33[31] != val_Rn_in[31]);
            end
            OP_AND: result = val_Rn_in & val2;
            OP_ORR: result = val_Rn_in | val2;
            OP_EOR: result = val_Rn_in ^ val2;
            default: result = 32'b0;
         endcase
      end
   end

   assign flags = {result[31], (result == 32'b0), flag_c, flag_v};

   // EX/MEM pipeline register, held while frozen
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_result       <= 32'b0;
         store_data       <= 32'b0;
         reg_file_dst_out <= 4'b0;
         mem_read_out     <= 1'b0;
         mem_write_out    <= 1'b0;
         WB_en_out        <= 1'b0;
      end else if (!freeze) begin
         alu_result       <= result;
         store_data       <= val_Rm_in;
         reg_file_dst_out <= reg_file_dst_in;
         mem_read_out     <= mem_read_in;
         mem_write_out    <= mem_write_in;
         WB_en_out        <= WB_en_in;
      end
   end

   // Architectural status register, written only by flag-setting instructions
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         status_out <= 4'b0;
      end else if (!freeze && SR_update_in) begin
         status_out <= flags;
      end
   end

   assign branch_taken = B_in;
   assign branch_addr  = pc_in + {{6{signed_immediate_in[23]}}, signed_immediate_in, 2'b00};

endmodule
